// File: rtl/blink_pattern_driver.sv
// Plays N-blink on/off patterns on an LED/buzzer pin from single-cycle request strobes,
// with a one-entry pending slot; further requests while the slot is full are dropped.
module blink_pattern_driver #(
    parameter int CLK_HZ = 50_000_000,
    parameter int ON_MS  = 100,
    parameter int OFF_MS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [3:0] n_blinks,
    output logic       out,
    output logic       busy,
    output logic       done,
    output logic       dropped
);

    localparam int ON_CYC  = CLK_HZ / 1000 * ON_MS;
    localparam int OFF_CYC = CLK_HZ / 1000 * OFF_MS;
    localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF
    } state_t;

    state_t           state, state_d;
    logic [3:0]       rem, rem_d;
    logic [3:0]       pend_n, pend_n_d;
    logic             pend_v, pend_v_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             req;
    logic             fin;
    logic             drop_d;
    logic             done_d;

    always_comb begin
        state_d  = state;
        rem_d    = rem;
        cnt_d    = cnt;
        pend_v_d = pend_v;
        pend_n_d = pend_n;
        drop_d   = 1'b0;

        req = trig && (n_blinks != 4'd0);
        fin = (state == S_OFF) && (cnt == OFF_LAST) && (rem == 4'd1);

        case (state)
            S_IDLE: begin
                if (req) begin
                    state_d = S_ON;
                    rem_d   = n_blinks;
                    cnt_d   = '0;
                end
            end
            S_ON: begin
                if (cnt == ON_LAST) begin
                    cnt_d   = '0;
                    state_d = S_OFF;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_OFF: begin
                if (cnt == OFF_LAST) begin
                    cnt_d = '0;
                    if (rem > 4'd1) begin
                        rem_d   = rem - 4'd1;
                        state_d = S_ON;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Completion hands the pending slot (or a same-cycle request) straight to the player,
        // so a request arriving exactly then is never dropped.
        if (state != S_IDLE) begin
            if (fin) begin
                if (pend_v) begin
                    rem_d   = pend_n;
                    state_d = S_ON;
                    if (req) begin
                        pend_n_d = n_blinks;
                    end else begin
                        pend_v_d = 1'b0;
                    end
                end else if (req) begin
                    rem_d   = n_blinks;
                    state_d = S_ON;
                end else begin
                    state_d = S_IDLE;
                end
            end else if (req) begin
                if (!pend_v) begin
                    pend_v_d = 1'b1;
                    pend_n_d = n_blinks;
                end else begin
                    drop_d = 1'b1;
                end
            end
        end

        // done is registered but must sit in the final OFF cycle, so look one cycle ahead.
        done_d = (state_d == S_OFF) && (cnt_d == OFF_LAST) && (rem_d == 4'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            rem     <= 4'd0;
            cnt     <= '0;
            pend_v  <= 1'b0;
            pend_n  <= 4'd0;
            out     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state   <= state_d;
            rem     <= rem_d;
            cnt     <= cnt_d;
            pend_v  <= pend_v_d;
            pend_n  <= pend_n_d;
            out     <= (state_d == S_ON);
            busy    <= (state_d != S_IDLE);
            done    <= done_d;
            dropped <= drop_d;
        end
    end

endmodule
